// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive controller.
package uart_pkg;

    localparam int unsigned PRESCALE_W   = 6;
    localparam int unsigned DEF_PRESCALE = 16;

    localparam logic [PRESCALE_W-1:0] PRESCALE_8  = 6'd8;
    localparam logic [PRESCALE_W-1:0] PRESCALE_16 = 6'd16;
    localparam logic [PRESCALE_W-1:0] PRESCALE_32 = 6'd32;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        QUAL     = 2'd1,
        ACTIVE   = 2'd2
    } rx_state_t;

    // Configuration payload driven to the receive core
    typedef struct packed {
        logic [PRESCALE_W-1:0] prescale;
        logic                  par_en;
        logic                  par_typ;
    } rx_cfg_t;

    // Only the oversampling ratios the core supports are accepted
    function automatic logic prescale_legal(input logic [PRESCALE_W-1:0] p);
        return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: DEPTH x 8 synchronous FIFO. The caller guarantees it never
// pushes when full (unless popping) and never pops when empty.
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [7:0]             wdata_i,
    output logic [7:0]             head_c,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   empty_o,
    output logic                   full_o
);
    import uart_pkg::*;

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_d;
    logic          empty_q;
    logic          full_q;

    // Next occupancy: simultaneous push and pop leave it unchanged
    always_comb begin
        level_d = level_q;
        if (push_i && !pop_i) begin
            level_d = level_q + LW'(1);
        end else if (pop_i && !push_i) begin
            level_d = level_q - LW'(1);
        end
    end

    // Pointers, level and registered empty/full flags
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_d;
            empty_q <= (level_d == '0);
            full_q  <= (level_d == LW'(DEPTH));
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign head_c  = mem_q[rd_ptr_q];
    assign level_o = level_q;
    assign empty_o = empty_q;
    assign full_o  = full_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: pad synchronisation, enable/idle qualification, core config
// and reset, RX byte FIFO and sticky error status for the bus side.
// Define UART_RX_CTRL_IRQ_EN to add the irq_thresh input and irq output.
module uart_rx_ctrl #(
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned DEF_PRESCALE = uart_pkg::DEF_PRESCALE
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_pad_in,
    output logic                   rx_line_out,
    output logic                   rx_core_rst,
    output logic [5:0]             prescale,
    output logic                   par_en,
    output logic                   par_typ,
    input  logic                   rx_data_valid,
    input  logic [7:0]             rx_p_data,
    input  logic                   rx_par_err,
    input  logic                   rx_stop_err,
    input  logic                   en_we,
    input  logic                   en_val,
    input  logic                   cfg_we,
    input  logic [5:0]             cfg_prescale,
    input  logic                   cfg_par_en,
    input  logic                   cfg_par_typ,
    output logic                   cfg_reject,
    input  logic                   rd_req,
    output logic                   rd_valid,
    output logic [7:0]             rd_data,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   fifo_empty,
    output logic                   fifo_full,
    output logic                   par_err_sticky,
    output logic                   stp_err_sticky,
    output logic                   overrun,
    input  logic                   err_clr
`ifdef UART_RX_CTRL_IRQ_EN
    ,
    input  logic [$clog2(DEPTH):0] irq_thresh,
    output logic                   irq
`endif
);
    import uart_pkg::*;

    rx_state_t   state_q, state_d;
    logic [5:0]  idle_cnt_q, idle_cnt_d;
    logic        sync1_q, pad_s_q;
    logic        line_q, core_rst_q;
    rx_cfg_t     cfg_q;
    logic        reject_q;
    logic        rd_valid_q;
    logic [7:0]  rd_data_q;
    logic        par_prev_q, stp_prev_q;
    logic        par_sticky_q, stp_sticky_q, ovr_q;

    logic        active_c, cfg_ok_c;
    logic        push_req_c, push_c, pop_c, ovr_set_c;
    logic        par_rise_c, stp_rise_c;
    logic [7:0]  head_c;

    // Two-flop synchroniser on the asynchronous pad, idle-high
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            pad_s_q <= 1'b1;
        end else begin
            sync1_q <= rx_pad_in;
            pad_s_q <= sync1_q;
        end
    end

    // Enable FSM next state; QUAL waits for prescale consecutive idle clocks
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = '0;
        unique case (state_q)
            DISABLED: begin
                if (en_we && en_val) state_d = QUAL;
            end
            QUAL: begin
                if (pad_s_q) begin
                    idle_cnt_d = idle_cnt_q + 6'd1;
                    if (idle_cnt_d == cfg_q.prescale) state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                state_d = ACTIVE;
            end
            default: begin
                state_d = DISABLED;
            end
        endcase
        if (en_we && !en_val) state_d = DISABLED;
    end

    // FSM state plus the line gate and core reset derived from next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DISABLED;
            idle_cnt_q <= '0;
            line_q     <= 1'b1;
            core_rst_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            line_q     <= (state_d == ACTIVE) ? sync1_q : 1'b1;
            core_rst_q <= (state_d != ACTIVE);
        end
    end

    assign active_c   = (state_q == ACTIVE);
    assign cfg_ok_c   = cfg_we && (state_q == DISABLED) && prescale_legal(cfg_prescale);

    assign pop_c      = rd_req && !fifo_empty;
    assign push_req_c = rx_data_valid && active_c;
    assign push_c     = push_req_c && (!fifo_full || pop_c);
    assign ovr_set_c  = push_req_c && fifo_full && !pop_c;

    assign par_rise_c = rx_par_err  && !par_prev_q && active_c;
    assign stp_rise_c = rx_stop_err && !stp_prev_q && active_c;

    // Core configuration: only legal prescales while disabled
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_q    <= '{prescale: 6'(DEF_PRESCALE), par_en: 1'b0, par_typ: 1'b0};
            reject_q <= 1'b0;
        end else begin
            if (cfg_ok_c) cfg_q <= '{prescale: cfg_prescale, par_en: cfg_par_en, par_typ: cfg_par_typ};
            reject_q <= cfg_we && !cfg_ok_c;
        end
    end

    uart_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_c),
        .pop_i   (pop_c),
        .wdata_i (rx_p_data),
        .head_c  (head_c),
        .level_o (fifo_level),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    // Read port: head registered on pop, rd_data holds otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= pop_c;
            if (pop_c) rd_data_q <= head_c;
        end
    end

    // Sticky status; a set event wins over a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            par_prev_q   <= 1'b0;
            stp_prev_q   <= 1'b0;
            par_sticky_q <= 1'b0;
            stp_sticky_q <= 1'b0;
            ovr_q        <= 1'b0;
        end else begin
            par_prev_q   <= rx_par_err;
            stp_prev_q   <= rx_stop_err;
            par_sticky_q <= par_rise_c | (par_sticky_q & ~err_clr);
            stp_sticky_q <= stp_rise_c | (stp_sticky_q & ~err_clr);
            ovr_q        <= ovr_set_c  | (ovr_q & ~err_clr);
        end
    end

`ifdef UART_RX_CTRL_IRQ_EN
    logic irq_q;

    // Interrupt on level threshold or any sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= ((fifo_level >= irq_thresh) && (irq_thresh != '0))
                     | ovr_q | par_sticky_q | stp_sticky_q;
        end
    end

    assign irq = irq_q;
`endif

    assign rx_line_out    = line_q;
    assign rx_core_rst    = core_rst_q;
    assign prescale       = cfg_q.prescale;
    assign par_en         = cfg_q.par_en;
    assign par_typ        = cfg_q.par_typ;
    assign cfg_reject     = reject_q;
    assign rd_valid       = rd_valid_q;
    assign rd_data        = rd_data_q;
    assign par_err_sticky = par_sticky_q;
    assign stp_err_sticky = stp_sticky_q;
    assign overrun        = ovr_q;

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Control and buffering wrapper around the UART receive core.
- Owns the receiver's configuration (prescale, parity enable and type), enable/idle qualification and core reset.
- Buffers received bytes in a FIFO and keeps sticky parity, stop and overrun status for the bus/CPU side.
- Sits between the RX pad and the receive core, and between the core and the SoC peripheral bus.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- DEF_PRESCALE, 16, prescale value loaded at reset.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rx_pad_in  in  1  asynchronous serial line from pad
- rx_line_out  out  1  qualified line to the core's RX_IN
- rx_core_rst  out  1  registered reset to the receive core
- prescale  out  6  to core
- par_en  out  1  to core
- par_typ  out  1  to core
- rx_data_valid  in  1  core byte-valid pulse
- rx_p_data  in  8  core parallel data
- rx_par_err  in  1  core parity error
- rx_stop_err  in  1  core stop error
- en_we  in  1  enable write strobe
- en_val  in  1  enable value
- cfg_we  in  1  config write strobe
- cfg_prescale  in  6  requested prescale
- cfg_par_en  in  1  requested parity enable
- cfg_par_typ  in  1  requested parity type
- cfg_reject  out  1  one-cycle pulse when a config write is refused
- rd_req  in  1  pop request
- rd_valid  out  1  rd_data valid (pulse)
- rd_data  out  8  popped byte
- fifo_level  out  $clog2(DEPTH)+1  entries held
- fifo_empty  out  1  FIFO empty
- fifo_full  out  1  FIFO full
- par_err_sticky  out  1  sticky parity error
- stp_err_sticky  out  1  sticky stop error
- overrun  out  1  sticky overrun
- err_clr  in  1  clears all three sticky bits

Behaviour:
- Reset values:
  - state DISABLED; rx_line_out=1; rx_core_rst=1.
  - prescale=DEF_PRESCALE; par_en=0; par_typ=0.
  - FIFO empty, level 0; rd_valid=0; rd_data=0.
  - All sticky bits 0; cfg_reject=0.
- Pad input passes through a 2-flop synchronizer (reset value 1) to give pad_s; 2-cycle latency.
- Enable state machine (DISABLED, QUAL, ACTIVE):
  - DISABLED -> QUAL on en_we & en_val.
  - QUAL: an idle counter runs while pad_s=1 and clears while pad_s=0. It moves to ACTIVE after pad_s=1 for prescale consecutive clocks.
  - en_we & !en_val returns to DISABLED from any state on the next edge. A write of the current enable value is a no-op.
  - rx_line_out = pad_s only in ACTIVE, otherwise 1.
  - rx_core_rst is registered: 1 in DISABLED and QUAL, 0 in ACTIVE. Disabling mid-frame therefore resets the core.
- Config writes:
  - Accepted only in DISABLED, and only when cfg_prescale is 8, 16 or 32. Outputs update on the next edge.
  - Any other write is ignored, cfg_reject pulses for 1 cycle, and outputs are unchanged.
- FIFO push:
  - On rx_data_valid in ACTIVE.
  - When full, the byte is dropped and overrun is set. Exception: if a pop happens in the same cycle, the push is accepted and overrun is not set.
  - rx_data_valid outside ACTIVE is ignored.
- FIFO pop:
  - rd_req while not empty gives rd_data = head and rd_valid=1 on the next cycle.
  - rd_req while empty is ignored, including a same-cycle push (no fall-through). rd_valid stays 0 and rd_data holds its last value.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. fifo_level is registered: push-only +1, pop-only -1, both or neither unchanged.
- Sticky errors:
  - A rising edge of rx_par_err or rx_stop_err (registered previous value) in ACTIVE sets the matching sticky bit; a long level counts as one event.
  - err_clr clears the sticky bits. If a set event and err_clr occur in the same cycle, the set wins.
- FIFO contents and sticky bits are kept across disable/enable. Only rst clears them.

Optional Feature:
- Macro UART_RX_CTRL_IRQ_EN.
- Defined:
  - Adds input irq_thresh ($clog2(DEPTH)+1 bits, reset-independent) and output irq.
  - irq is registered: (fifo_level >= irq_thresh && irq_thresh != 0) | overrun | par_err_sticky | stp_err_sticky.
  - irq resets to 0.
- Undefined: neither port exists and there is no interrupt logic.

Decomposition:
- Package uart_pkg holds:
  - rx_state_t enum (DISABLED, QUAL, ACTIVE);
  - PRESCALE_8/16/32 constants and the legality check function;
  - DEF_PRESCALE value.
- One sub-module, uart_rx_fifo: parameterised DEPTH x 8 sync FIFO with push, pop, level, empty and full. The controller instantiates it and owns the overrun logic.

Test Plan:
- Reset, then cfg_we with prescale=32, par_en=1, par_typ=1 in DISABLED -> prescale=32, par_en=1, par_typ=1 next cycle, cfg_reject=0. Retry with prescale=12 -> cfg_reject pulses and values are unchanged.
- Enable while the pad is held low, then release it high -> rx_line_out stays 1 throughout low. It follows pad only after pad_s=1 for 32 consecutive clocks, and rx_core_rst drops to 0 the same cycle ACTIVE is entered.
- Push 0xA5, 0x3C, then rd_req twice -> rd_data 0xA5 then 0x3C, each with a 1-cycle rd_valid. Level goes 0,1,2,1,0.
- Fill DEPTH=8 with 0x00..0x07, push 0xFF -> overrun=1 and 0xFF dropped. Repeat full with push 0xEE + rd_req in the same cycle -> overrun stays 0 and 0xEE is the last byte read out.
- rx_par_err held high for 5 cycles -> par_err_sticky=1. err_clr pulsed on the same cycle as a new rx_stop_err rising edge -> par_err_sticky=0, stp_err_sticky=1.
- Disable mid-frame -> rx_core_rst=1 and rx_line_out=1 next cycle, FIFO level kept. With UART_RX_CTRL_IRQ_EN and irq_thresh=3, the third push asserts irq.
